// File: rtl/mul_seq_if.sv
// mul_seq_if: request/response bundle between the multi-cycle core and the
// iterative multiplier.
//   Start        request a multiply (only looked at while the sequencer idles)
//   SrcA, SrcB   operands, needed only in the cycle Start is accepted
//   Result       low WIDTH bits of SrcA*SrcB, registered
//   Flags        {N,Z} of Result, registered
//   Busy         iteration in progress
//   Done         one-cycle pulse when Result/Flags have just been loaded
//   Stall        hold the issuing FSM in its execute state
// master = issuing side (core / bench), slave = mul_seq.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] Result;
  logic [1:0]       Flags;
  logic             Busy;
  logic             Done;
  logic             Stall;

  modport master (
    output Start, SrcA, SrcB,
    input  Result, Flags, Busy, Done, Stall
  );

  modport slave (
    input  Start, SrcA, SrcB,
    output Result, Flags, Busy, Done, Stall
  );
endinterface

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add multiplier producing the low WIDTH bits of
// SrcA*SrcB, one multiplier bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   bus        mul_seq_if.slave (Start/SrcA/SrcB in; Result/Flags/Busy/Done/Stall out)
//   dbg_state  current FSM state (0=IDLE, 1=RUN, 2=DONE) for observation
//
// Handshake: a request is accepted on any rising edge where the sequencer is
// IDLE and Start=1; operands are captured on that edge and are don't-care
// afterwards. Stall is high combinationally from the request cycle until the
// last RUN cycle, so the issuer holds its state; Done is high for exactly the
// one cycle Stall drops, which is when Result/Flags are valid and new. Start
// seen outside IDLE is ignored, so the earliest follow-on request is the
// cycle after Done.
//
// Optional feature macro: MUL_EARLY_EXIT_EN. When defined, RUN also ends as
// soon as the remaining multiplier bits are all zero; results are unchanged,
// only latency shrinks. Undefined, every operation takes WIDTH RUN cycles.
module mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mul_seq_if.slave   bus,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] result_q;
  logic [1:0]       flags_q;

  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] b_shift;
  logic [CW-1:0]    count_next;
  logic             run_last;

  // One iteration: add the multiplicand when the current multiplier bit is set.
  assign acc_next   = b_q[0] ? (acc + a_q) : acc;
  assign b_shift    = b_q >> 1;
  assign count_next = count + CW'(1);

`ifdef MUL_EARLY_EXIT_EN
  // Once no set multiplier bits remain, further iterations cannot change acc.
  assign run_last = (count_next == CW'(WIDTH)) || (b_shift == '0);
`else
  assign run_last = (count_next == CW'(WIDTH));
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.Start) state_next = S_RUN;
      S_RUN:   if (run_last)  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result/flag load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
      flags_q  <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            a_q   <= bus.SrcA;
            b_q   <= bus.SrcB;
            acc   <= '0;
            count <= '0;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          a_q   <= a_q << 1;
          b_q   <= b_shift;
          count <= count_next;
          if (run_last) begin
            result_q <= acc_next;
            flags_q  <= {acc_next[WIDTH-1], (acc_next == '0)};
          end
        end
        default: ;
      endcase
    end
  end

  // Busy/Done are decodes of the registered state, so they are glitch-free
  // and clear together with the state on reset.
  assign bus.Result = result_q;
  assign bus.Flags  = flags_q;
  assign bus.Busy   = (state == S_RUN);
  assign bus.Done   = (state == S_DONE);
  assign bus.Stall  = ((state == S_IDLE) && bus.Start) || (state == S_RUN);
  assign dbg_state  = state;

endmodule
